// File: rtl/dutmem_burst_ctrl.sv
// Burst access controller sitting in front of a single-port synchronous RAM.
// Write bursts stream beats straight into the RAM; read bursts issue RAM
// reads only when the two-entry output buffer is guaranteed to have room for
// the returning word, so rd_ready backpressure never loses data and a
// consumer holding rd_ready high sees one beat per cycle.
module dutmem_burst_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [LWIDTH-1:0] cmd_len,
    // write beat channel
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_data,
    // read beat channel
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_last,
    // status
    output logic              busy,
    // RAM side
    output logic              mem_ce,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LWIDTH-1:0] remaining_q, remaining_d;

    // A RAM read was issued last cycle; its word is on mem_dout this cycle.
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    // Output buffer bookkeeping: two entries addressed by one-bit pointers.
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [DWIDTH-1:0] entry_data [2];
    logic              entry_last [2];

    logic              pop;
    logic              capture;
    logic              issue;
    logic              wr_beat;
    logic [2:0]        occupancy;

    // Handshake qualifiers and the read issue condition.
    always_comb begin
        pop       = (count_q != 2'd0) && rd_ready;
        capture   = inflight_q;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        // A new read may go out only if, after this cycle's pop, the words
        // already buffered plus the one in flight leave a free slot.
        issue     = (state_q == READ) && (occupancy < (3'd2 + {2'b00, pop}));
        wr_beat   = (state_q == WRITE) && wr_valid;
    end

    // Channel and RAM outputs, all decoded from state and current inputs.
    always_comb begin
        cmd_ready = (state_q == IDLE);
        wr_ready  = (state_q == WRITE);
        mem_ce    = wr_beat || issue;
        mem_we    = wr_beat;
        mem_addr  = (wr_beat || issue) ? cur_addr_q : '0;
        mem_din   = wr_beat ? wr_data : '0;
        rd_valid  = (count_q != 2'd0);
        rd_data   = entry_data[rd_ptr_q];
        rd_last   = entry_last[rd_ptr_q];
        busy      = (state_q != IDLE) || (count_q != 2'd0);
    end

    // Next-state logic for the burst FSM, counters and buffer pointers.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == '0);
        rd_ptr_d        = rd_ptr_q ^ pop;
        wr_ptr_d        = wr_ptr_q ^ capture;
        count_d         = count_q + {1'b0, capture} - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    state_d     = cmd_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Done once nothing is in flight and the final pop empties
                // the buffer.
                if (!inflight_q && (count_d == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and buffer-pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
        end
    end

    // One storage slot per buffer entry; the returning RAM word lands in the
    // slot named by the write pointer together with its last-beat tag.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        localparam logic SLOT = 1'(gi);

        logic [DWIDTH-1:0] data_q;
        logic              last_q;

        // Capture the RAM word into this slot when it is the write target.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                data_q <= '0;
                last_q <= 1'b0;
            end else if (capture && (wr_ptr_q == SLOT)) begin
                data_q <= mem_dout;
                last_q <= inflight_last_q;
            end
        end

        assign entry_data[gi] = data_q;
        assign entry_last[gi] = last_q;
    end

endmodule

// File: tb/tb_dutmem_burst_ctrl.sv
// Scoreboard bench for dutmem_burst_ctrl with a behavioural single-port RAM.
// Drivers push expected RAM writes and read beats into queues; a monitor
// process compares them against what the DUT actually presents.
module tb_dutmem_burst_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 8;

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    dutmem_burst_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered read, dout held when not reading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            else        mem_dout      <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] wdata  [0:15];
    bit            wpat   [0:7];
    int            wpat_len;
    bit            rr_pat [0:7];
    bit            rr_pat_en;
    int            pops_seen;
    int            n_checks;
    int            n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // Present a command and hold it until accepted; returns 1 time unit after
    // the accepting edge with cmd_valid dropped.
    task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        int cyc;
        cyc       = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check1("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd we=%0b addr=0x%03h len=%0d", we, addr, len);
    endtask

    // Write burst from wdata[], wr_valid following wpat[]; expected RAM
    // writes go to the scoreboard and the shadow model.
    task automatic do_write(input logic [AW-1:0] addr, input int len);
        int beat;
        int k;
        logic [AW-1:0] a;
        wr_exp_t w;
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i);
            w.addr = a;
            w.data = wdata[i];
            wr_q.push_back(w);
            shadow[a] = wdata[i];
        end
        send_cmd(1'b1, addr, LW'(len));
        beat = 0;
        k    = 0;
        while (beat <= len && k < 100) begin
            wr_valid = wpat[k % wpat_len];
            wr_data  = wdata[beat];
            k++;
            @(negedge clk);
            check1("wr_ready_in_burst", wr_ready, 1'b1);
            check1("mem_ce_follows_wr_valid", mem_ce, wr_valid);
            if (wr_valid) beat++;
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check1("wr_ready_after_burst", wr_ready, 1'b0);
        check1("cmd_ready_after_write", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [AW-1:0] addr, input int len);
        rd_exp_t e;
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i);
            e.data = shadow[a];
            e.last = (i == len);
            rd_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((rd_q.size() != 0 || busy) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check1({name, "_drained"}, (rd_q.size() == 0) && !busy, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Consumer: rd_ready high, or following rr_pat[] when enabled.
    initial begin
        int idx;
        idx      = 0;
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_pat_en) begin
                rd_ready = rr_pat[idx];
                idx      = (idx + 1) % 8;
            end else begin
                rd_ready = 1'b1;
                idx      = 0;
            end
        end
    end

    // Monitor: compares read beats and RAM writes against the scoreboard,
    // checks hold-while-stalled and the issue-occupancy bound.
    initial begin
        int            outstanding;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        bit            stall;
        bit            p;
        bit            iss;
        rd_exp_t       e;
        wr_exp_t       w;
        outstanding = 0;
        prev_data   = '0;
        prev_last   = 1'b0;
        stall       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                outstanding = 0;
                stall       = 1'b0;
            end else begin
                p   = rd_valid && rd_ready;
                iss = mem_ce && !mem_we;
                if (stall) begin
                    check("rd_data_hold", rd_data, prev_data);
                    check1("rd_last_hold", rd_last, prev_last);
                end
                if (iss) check1("issue_occupancy", (outstanding - int'(p)) < 2, 1'b1);
                outstanding = outstanding + int'(iss) - int'(p);
                if (p) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rd_unexpected: got beat 0x%0h, expected none", rd_data);
                    end else begin
                        e = rd_q.pop_front();
                        check("rd_data", rd_data, e.data);
                        check1("rd_last", rd_last, e.last);
                        $display("rd beat data=0x%08h last=%0b", rd_data, rd_last);
                    end
                    pops_seen++;
                end
                if (mem_ce && mem_we) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mem_wr_unexpected: got addr 0x%0h, expected none", mem_addr);
                    end else begin
                        w = wr_q.pop_front();
                        check("mem_wr_addr", 32'(mem_addr), 32'(w.addr));
                        check("mem_wr_data", mem_din, w.data);
                        $display("mem wr addr=0x%03h data=0x%08h", mem_addr, mem_din);
                    end
                end
                stall     = rd_valid && !rd_ready;
                prev_data = rd_data;
                prev_last = rd_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        n_checks  = 0;
        n_fail    = 0;
        pops_seen = 0;
        rr_pat_en = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rstn      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_wr_ready", wr_ready, 1'b0);
        check1("rst_rd_valid", rd_valid, 1'b0);
        check1("rst_rd_last", rd_last, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_mem_ce", mem_ce, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Wrapping write burst, wr_valid held high.
        for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
        wpat[0]  = 1'b1;
        wpat_len = 1;
        do_write(10'h3FE, 3);

        // Wrapping read burst, latency and back-to-back beats.
        push_read(10'h3FE, 3);
        send_cmd(1'b0, 10'h3FE, 8'd3);
        @(negedge clk);
        check1("rd_first_ce_a1", mem_ce, 1'b1);
        check("rd_first_addr_a1", 32'(mem_addr), 32'h3FE);
        check1("rd_valid_a1", rd_valid, 1'b0);
        @(negedge clk);
        check1("rd_valid_a2", rd_valid, 1'b0);
        @(negedge clk);
        check1("rd_valid_a3", rd_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("rd_back_to_back", rd_valid, 1'b1);
        end
        @(negedge clk);
        check1("rd_busy_after_last", busy, 1'b0);
        check1("rd_valid_after_last", rd_valid, 1'b0);
        check1("rd_cmd_ready_after_last", cmd_ready, 1'b1);
        check("rd_all_beats_seen", 32'(rd_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Eight-beat read under an irregular rd_ready pattern.
        for (int i = 0; i < 8; i++) wdata[i] = 32'hB0 + 32'(i);
        do_write(10'h100, 7);
        rr_pat[0] = 1; rr_pat[1] = 0; rr_pat[2] = 0; rr_pat[3] = 1;
        rr_pat[4] = 0; rr_pat[5] = 1; rr_pat[6] = 1; rr_pat[7] = 0;
        rr_pat_en = 1'b1;
        push_read(10'h100, 7);
        send_cmd(1'b0, 10'h100, 8'd7);
        wait_drain("rd_backpressure");
        rr_pat_en = 1'b0;

        // Write burst with gaps in wr_valid.
        for (int i = 0; i < 4; i++) wdata[i] = 32'hC0 + 32'(i);
        wpat[0] = 1; wpat[1] = 0; wpat[2] = 1; wpat[3] = 1; wpat[4] = 0; wpat[5] = 1;
        wpat_len = 6;
        do_write(10'h200, 3);
        check("wr_gap_all_written", 32'(wr_q.size()), 32'h0);
        wpat[0]  = 1'b1;
        wpat_len = 1;

        // Reset in the middle of a read burst, then re-read everything.
        base = pops_seen;
        push_read(10'h100, 5);
        send_cmd(1'b0, 10'h100, 8'd5);
        cyc = 0;
        while (pops_seen < base + 2 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("rst_mid_two_popped", 32'(pops_seen - base), 32'd2);
        #1;
        rstn = 1'b0;
        #1;
        check1("rst_mid_rd_valid", rd_valid, 1'b0);
        check1("rst_mid_busy", busy, 1'b0);
        check1("rst_mid_cmd_ready", cmd_ready, 1'b1);
        check1("rst_mid_mem_ce", mem_ce, 1'b0);
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        push_read(10'h100, 5);
        send_cmd(1'b0, 10'h100, 8'd5);
        wait_drain("rst_reread");

        // Single-beat write then read, with the read command held early.
        wdata[0] = 32'h5A5A5A5A;
        begin
            wr_exp_t w;
            w.addr = 10'h010;
            w.data = wdata[0];
            wr_q.push_back(w);
            shadow[10'h010] = wdata[0];
        end
        push_read(10'h010, 0);
        send_cmd(1'b1, 10'h010, 8'd0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 10'h010;
        cmd_len   = 8'd0;
        wr_valid  = 1'b1;
        wr_data   = wdata[0];
        @(negedge clk);
        check1("held_cmd_blocked", cmd_ready, 1'b0);
        check1("single_wr_ce", mem_ce, 1'b1);
        check("single_wr_addr", 32'(mem_addr), 32'h010);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check1("held_cmd_idle_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check1("held_cmd_read_issue", mem_ce && !mem_we, 1'b1);
        wait_drain("single_beat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
